e_mdu: RTL and testbench
========================

# e_mdu

Execute-stage multiply/divide unit. It sits beside the ALU in E and feeds the EX/MEM pipeline register: its `E_MDU_Out` is muxed into `E_ALURes` for `mfhi`/`mflo`. The block owns the architectural HI/LO registers and models fixed multi-cycle latencies for `mult`/`multu` (5 cycles) and `div`/`divu` (10 cycles). It provides `E_MDU_Busy` and a stall request that the hazard unit uses to freeze D when an MDU instruction would collide.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `E_MDU_Start`  in  1  an MDU instruction is valid in E this cycle.
- `E_MDU_Op`  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 are treated as none.
- `E_A`  in  32  rs operand, already forwarded.
- `E_B`  in  32  rt operand, already forwarded.
- `E_MDU_Busy`  out  1  a multi-cycle operation is in flight.
- `E_MDU_Stall`  out  1  combinational: `E_MDU_Busy | (E_MDU_Start & op ∈ {1..4})`.
- `E_MDU_Out`  out  32  combinational: HI when op = 5, LO when op = 6, otherwise 0.
- `E_HI`, `E_LO`  out  32 each  architectural HI/LO, for debug and trace.

## Operation
- State consists of HI, LO, `pend_hi`, `pend_lo`, a 4-bit down-counter `cnt`, and `busy`.
- An op is accepted when `E_MDU_Start = 1` and `busy = 0`. When `busy = 1`, every Start is ignored. Upstream stalling must prevent this case; the bench flags it with an assertion.
- mult: `{pend_hi, pend_lo} = $signed(E_A) * $signed(E_B)` as a 64-bit result. multu uses the unsigned 64-bit product.
- div: `pend_lo` = quotient truncated toward zero; `pend_hi` = remainder with the sign of the dividend.
  - Special case 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- divu: unsigned quotient to `pend_lo`, remainder to `pend_hi`.
- Divide by zero (div or divu with `E_B = 0`):
  - Busy is still asserted for `DIV_CYCLES` cycles.
  - On completion HI and LO are left unchanged.
- Pending results are captured at the accept edge. Later changes on `E_A`/`E_B` have no effect.
- mthi / mtlo: write `E_A` to HI / LO at the accept edge. No busy is asserted.
- mfhi / mflo: pure read through `E_MDU_Out`, with no state change. The result is correct only while `busy = 0`; the hazard unit guarantees this.
- State machine:
  - IDLE (`busy = 0`) → on accept of op 1–4: RUN, with `busy = 1` and `cnt = N − 1`.
  - RUN, `cnt ≠ 0`: `cnt--`.
  - RUN, `cnt = 0`: commit the pending values to HI/LO (subject to the divide-by-zero rule), `busy = 0`, return to IDLE.

## Timing
- Reset (`rst = 0`, async): HI = LO = 0, `pend_*` = 0, `cnt` = 0, `busy` = 0, so `E_MDU_Busy = 0`. An in-flight op is discarded. Operation resumes on the first rising edge with `rst = 1`.
- Latency for an op of N cycles accepted at the edge ending cycle T:
  - `E_MDU_Busy` = 1 during cycles T+1 … T+N.
  - HI/LO are updated at the edge ending T+N and are visible from cycle T+N+1, when `busy` = 0.
- Back-to-back ops:
  - A Start in cycle T+N is ignored because `busy = 1`.
  - The earliest new accept is cycle T+N+1.
  - An mfhi/mflo in T+N+1 returns the new HI/LO.
- mthi/mtlo accepted at edge T are visible to mfhi/mflo from cycle T+1.
- `E_MDU_Stall` rises combinationally in the cycle a mult/div sits in E with `busy = 0`. It stays high through cycle T+N.

## Test plan
- mult: `E_A = 0xFFFFFFFE`, `E_B = 3` → Busy high for exactly 5 cycles; afterwards HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. The same operands with multu → HI = 0x00000002, LO = 0xFFFFFFFA.
- div: `E_A = 0xFFFFFFF9` (−7), `E_B = 2` → Busy high 10 cycles; then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. The same operands with divu → LO = 0x7FFFFFFC, HI = 1.
- Divide by zero: first mthi 0x11, mtlo 0x22, then div with `E_B = 0` → Busy high 10 cycles; HI = 0x11 and LO = 0x22 unchanged.
- Ignored start: during a mult, pulse Start with mtlo `E_A = 0x55` at busy cycle 3 → LO ends as the mult result, not 0x55. An mflo issued in the cycle after busy falls returns the product.
- Reset mid-op: assert `rst = 0` (async, between edges) at div busy cycle 4 → Busy = 0 and HI = LO = 0 immediately. After release, mult 6 × 7 gives LO = 42 after 5 busy cycles.
- Corner: div 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0. The `E_MDU_Stall` waveform matches the Busy window plus the start cycle.

Source files
------------

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/div with a fixed
// multi-cycle latency and raises a stall request while a result is pending.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        E_MDU_Start,
    input  logic [3:0]  E_MDU_Op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_MDU_Busy,
    output logic        E_MDU_Stall,
    output logic [31:0] E_MDU_Out,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_dz_q, pend_dz_d;

    // Start/Busy handshake: Start is a request that is taken only at a rising
    // edge where Busy is low; any Start seen while Busy is high is dropped, so
    // upstream must hold the instruction (via E_MDU_Stall) until Busy falls.
    logic accept;
    logic is_md;
    assign accept = E_MDU_Start && (state_q == IDLE);
    assign is_md  = (E_MDU_Op >= OP_MULT) && (E_MDU_Op <= OP_DIVU);

    logic [63:0] prod_s, prod_u;
    assign prod_u = {32'd0, E_A} * {32'd0, E_B};
    assign prod_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};

    logic        b_zero;
    logic [31:0] a_mag, b_mag, uq, ur, sq_mag, sr_mag, sq, sr;
    assign b_zero = (E_B == 32'd0);
    assign a_mag  = E_A[31] ? -E_A : E_A;
    assign b_mag  = E_B[31] ? -E_B : E_B;
    assign uq     = b_zero ? 32'd0 : E_A / E_B;
    assign ur     = b_zero ? 32'd0 : E_A % E_B;
    assign sq_mag = b_zero ? 32'd0 : a_mag / b_mag;
    assign sr_mag = b_zero ? 32'd0 : a_mag % b_mag;
    // Magnitude division; 0x80000000 / -1 wraps back to 0x80000000 naturally.
    assign sq     = (E_A[31] ^ E_B[31]) ? -sq_mag : sq_mag;
    assign sr     = E_A[31] ? -sr_mag : sr_mag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (E_MDU_Op)
                        OP_MULT, OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = (E_MDU_Op == OP_MULT) ? prod_s : prod_u;
                            pend_dz_d = 1'b0;
                            cnt_d     = 4'(MULT_CYCLES - 1);
                            state_d   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = (E_MDU_Op == OP_DIV) ? sr : ur;
                            pend_lo_d = (E_MDU_Op == OP_DIV) ? sq : uq;
                            pend_dz_d = b_zero;
                            cnt_d     = 4'(DIV_CYCLES - 1);
                            state_d   = RUN;
                        end
                        OP_MTHI: hi_d = E_A;
                        OP_MTLO: lo_d = E_A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Divide by zero burns the full latency but leaves HI/LO alone.
                    if (!pend_dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (E_MDU_Op)
            OP_MFHI: E_MDU_Out = hi_q;
            OP_MFLO: E_MDU_Out = lo_q;
            default: E_MDU_Out = 32'd0;
        endcase
    end

    assign E_MDU_Busy  = (state_q == RUN);
    assign E_MDU_Stall = E_MDU_Busy | (E_MDU_Start & is_md);
    assign E_HI        = hi_q;
    assign E_LO        = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed vector table, hand-built multi-cycle corner cases
// and a short randomized run, all checked against a scoreboard of HI/LO pairs.
module tb_e_mdu;

    logic        clk;
    logic        rst;
    logic        E_MDU_Start;
    logic [3:0]  E_MDU_Op;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_MDU_Busy;
    logic        E_MDU_Stall;
    logic [31:0] E_MDU_Out;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .E_MDU_Start (E_MDU_Start),
        .E_MDU_Op    (E_MDU_Op),
        .E_A         (E_A),
        .E_B         (E_B),
        .E_MDU_Busy  (E_MDU_Busy),
        .E_MDU_Stall (E_MDU_Stall),
        .E_MDU_Out   (E_MDU_Out),
        .E_HI        (E_HI),
        .E_LO        (E_LO)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   errors   = 0;
    int   n_checks = 0;
    logic allow_busy_start = 1'b0;

    // scoreboard of expected {HI, LO} after each operation
    logic [63:0] exp_q[$];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[11];

    always @(posedge clk) begin
        if (rst && E_MDU_Start && E_MDU_Busy && !allow_busy_start)
            $error("FAIL start_while_busy op=%0d", E_MDU_Op);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int latency(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2) return 5;
        if (op == 4'd3 || op == 4'd4) return 10;
        return 0;
    endfunction

    // Drive one op, count busy cycles, then read HI/LO back with mfhi/mflo in
    // the first cycle after busy falls. inject > 0 pulses an mtlo 0x55 at that
    // busy cycle, which must be ignored.
    task automatic run_op(input logic [3:0] t_op, input logic [31:0] t_a,
                          input logic [31:0] t_b, input int inject);
        logic [63:0] exp;
        int n;
        int exp_n;
        exp_n = latency(t_op);
        @(negedge clk);
        E_MDU_Start = 1'b1;
        E_MDU_Op    = t_op;
        E_A         = t_a;
        E_B         = t_b;
        #1;
        check("stall_accept", {31'd0, E_MDU_Stall}, {31'd0, exp_n != 0});
        if (t_op < 4'd5 || t_op > 4'd6)
            check("out_idle", E_MDU_Out, 32'd0);
        @(negedge clk);
        E_MDU_Start = 1'b0;
        E_MDU_Op    = 4'd0;
        E_A         = $urandom;
        E_B         = $urandom;
        n = 0;
        while (E_MDU_Busy && n < 40) begin
            n++;
            check("stall_busy", {31'd0, E_MDU_Stall}, 32'd1);
            if (n == inject) begin
                allow_busy_start = 1'b1;
                E_MDU_Start      = 1'b1;
                E_MDU_Op         = 4'd8;
                E_A              = 32'h55;
            end
            @(negedge clk);
            allow_busy_start = 1'b0;
            E_MDU_Start      = 1'b0;
            E_MDU_Op         = 4'd0;
        end
        check("busy_cycles", 32'(n), 32'(exp_n));
        check("stall_after", {31'd0, E_MDU_Stall}, 32'd0);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            exp = exp_q.pop_front();
            E_MDU_Start = 1'b1;
            E_MDU_Op    = 4'd5;
            #1 check("mfhi", E_MDU_Out, exp[63:32]);
            check("hi_reg", E_HI, exp[63:32]);
            E_MDU_Op = 4'd6;
            #1 check("mflo", E_MDU_Out, exp[31:0]);
            check("lo_reg", E_LO, exp[31:0]);
            E_MDU_Start = 1'b0;
            E_MDU_Op    = 4'd0;
        end
    endtask

    initial begin
        logic [31:0]        ra, rb;
        logic signed [63:0] sa, sb;
        logic [63:0]        p;
        logic [3:0]         rop;

        vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'd3,          32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{4'd2, 32'hFFFFFFFE, 32'd3,          32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{4'd4, 32'hFFFFFFF9, 32'd2,          32'h00000001, 32'h7FFFFFFC};
        vecs[4]  = '{4'd7, 32'h00000011, 32'd0,          32'h00000011, 32'h7FFFFFFC};
        vecs[5]  = '{4'd8, 32'h00000022, 32'd0,          32'h00000011, 32'h00000022};
        vecs[6]  = '{4'd3, 32'h12345678, 32'd0,          32'h00000011, 32'h00000022};
        vecs[7]  = '{4'd4, 32'h87654321, 32'd0,          32'h00000011, 32'h00000022};
        vecs[8]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF,   32'h00000000, 32'h80000000};
        vecs[9]  = '{4'd6, 32'hDEADBEEF, 32'h0,          32'h00000000, 32'h80000000};
        vecs[10] = '{4'd12, 32'hCAFEF00D, 32'h5,         32'h00000000, 32'h80000000};

        rst         = 1'b0;
        E_MDU_Start = 1'b0;
        E_MDU_Op    = 4'd0;
        E_A         = 32'd0;
        E_B         = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_busy", {31'd0, E_MDU_Busy}, 32'd0);
        check("reset_hi", E_HI, 32'd0);
        check("reset_lo", E_LO, 32'd0);

        for (int i = 0; i < 11; i++) begin
            exp_q.push_back({vecs[i].exp_hi, vecs[i].exp_lo});
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0);
        end

        // mtlo pulsed at busy cycle 3 of a mult must be dropped
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, 3);

        // asynchronous reset at div busy cycle 4
        @(negedge clk);
        E_MDU_Start = 1'b1;
        E_MDU_Op    = 4'd4;
        E_A         = 32'd100;
        E_B         = 32'd7;
        @(negedge clk);
        E_MDU_Start = 1'b0;
        E_MDU_Op    = 4'd0;
        repeat (3) @(negedge clk);
        check("busy_before_reset", {31'd0, E_MDU_Busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midop_reset_busy", {31'd0, E_MDU_Busy}, 32'd0);
        check("midop_reset_hi", E_HI, 32'd0);
        check("midop_reset_lo", E_LO, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back({32'd0, 32'd42});
        run_op(4'd1, 32'd6, 32'd7, 0);

        // randomized mult / multu / divu against a bench model
        for (int i = 0; i < 8; i++) begin
            rop = 4'($urandom_range(0, 2));
            rop = (rop == 4'd0) ? 4'd1 : (rop == 4'd1) ? 4'd2 : 4'd4;
            ra  = $urandom;
            rb  = (rop == 4'd4) ? 32'($urandom_range(1, 100000)) : $urandom;
            if (rop == 4'd1) begin
                sa = $signed(ra);
                sb = $signed(rb);
                p  = sa * sb;
            end else if (rop == 4'd2) begin
                p = {32'd0, ra} * {32'd0, rb};
            end else begin
                p = {ra % rb, ra / rb};
            end
            exp_q.push_back(p);
            run_op(rop, ra, rb, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
